// File: rtl/stack_engine.sv
// stack_engine: 6502 stack pointer owner with multi-byte PUSH/POP/LOAD/PEEK
// commands, one byte per req/ack memory transaction.
// WRAP=1 wraps sp silently; WRAP=0 refuses a byte at the boundary and flags it.
// Optional feature macro: STACK_PEEK_EN (op 3 reads without moving sp;
// when undefined op 3 completes as a NOP).
module stack_engine #(
    parameter int                     ADDR_W    = 16,
    parameter int                     SP_W      = 8,
    parameter int                     DATA_W    = 8,
    parameter logic [ADDR_W-SP_W-1:0] PAGE      = 'h01,
    parameter logic [SP_W-1:0]        SP_RESET  = '1,
    parameter int                     MAX_BYTES = 3,
    parameter int                     WRAP      = 1,
    localparam int                    LEN_W     = $clog2(MAX_BYTES + 1)
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        cmd_valid,
    output logic                        cmd_ready,
    input  logic [1:0]                  cmd_op,
    input  logic [LEN_W-1:0]            cmd_len,
    input  logic [MAX_BYTES*DATA_W-1:0] cmd_wdata,
    input  logic [SP_W-1:0]             cmd_sp_data,
    output logic                        rsp_valid,
    output logic [MAX_BYTES*DATA_W-1:0] rsp_rdata,
    output logic                        err_overflow,
    output logic                        err_underflow,
    output logic                        mem_req,
    output logic                        mem_we,
    output logic [ADDR_W-1:0]           mem_addr,
    output logic [DATA_W-1:0]           mem_wdata,
    input  logic                        mem_ack,
    input  logic [DATA_W-1:0]           mem_rdata,
    output logic [SP_W-1:0]             sp,
    output logic                        busy
);

    localparam int IDX_W = (MAX_BYTES > 1) ? $clog2(MAX_BYTES) : 1;

    localparam logic [1:0] OP_PUSH = 2'd0;
    localparam logic [1:0] OP_POP  = 2'd1;
    localparam logic [1:0] OP_LOAD = 2'd2;
    localparam logic [1:0] OP_PEEK = 2'd3;

`ifdef STACK_PEEK_EN
    typedef enum logic [2:0] {S_IDLE, S_PUSH, S_POP, S_PEEK, S_DONE} state_t;
`else
    typedef enum logic [2:0] {S_IDLE, S_PUSH, S_POP, S_DONE} state_t;
`endif

    state_t                            r_state, w_next;
    logic [SP_W-1:0]                   r_sp;
    logic [LEN_W-1:0]                  r_len, r_idx;
    logic [MAX_BYTES-1:0][DATA_W-1:0]  r_wdata, r_rdata;
    logic                              r_ovf, r_udf;

    logic [LEN_W-1:0]                  w_len, w_wpos;
    logic [IDX_W-1:0]                  w_wsel, w_rsel;
    logic                              w_last, w_refuse, w_fire;
`ifdef STACK_PEEK_EN
    logic [SP_W-1:0]                   w_peek_sp;
    assign w_peek_sp = r_sp + SP_W'(r_idx);
`endif

    // Oversized lengths clamp to the widest supported frame
    assign w_len  = (cmd_len > LEN_W'(MAX_BYTES)) ? LEN_W'(MAX_BYTES) : cmd_len;
    // Pushes go out high byte first, pops fill from byte 0 upward
    assign w_wpos = r_len - r_idx - LEN_W'(1);
    assign w_wsel = IDX_W'(w_wpos);
    assign w_rsel = IDX_W'(r_idx);
    assign w_last = (r_idx == r_len - LEN_W'(1));
    assign w_fire = mem_req && mem_ack;

    assign cmd_ready     = (r_state == S_IDLE);
    assign busy          = ~cmd_ready;
    assign rsp_valid     = (r_state == S_DONE);
    assign rsp_rdata     = r_rdata;
    assign sp            = r_sp;
    assign err_overflow  = (WRAP == 0) && rsp_valid && r_ovf;
    assign err_underflow = (WRAP == 0) && rsp_valid && r_udf;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_next;
    end

    // Next state and memory bus; boundary refusal suppresses mem_req outright
    always_comb begin
        w_next    = r_state;
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = {PAGE, r_sp};
        mem_wdata = r_wdata[w_wsel];
        w_refuse  = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (cmd_valid) begin
                    case (cmd_op)
                        OP_PUSH: w_next = (w_len == '0) ? S_DONE : S_PUSH;
                        OP_POP:  w_next = (w_len == '0) ? S_DONE : S_POP;
`ifdef STACK_PEEK_EN
                        OP_PEEK: w_next = (w_len == '0) ? S_DONE : S_PEEK;
`else
                        OP_PEEK: w_next = S_DONE;
`endif
                        default: w_next = S_DONE;
                    endcase
                end
            end
            S_PUSH: begin
                if (WRAP == 0 && r_sp == '0) begin
                    w_refuse = 1'b1;
                    w_next   = S_DONE;
                end else begin
                    mem_req = 1'b1;
                    mem_we  = 1'b1;
                    if (mem_ack && w_last) w_next = S_DONE;
                end
            end
            S_POP: begin
                if (WRAP == 0 && r_sp == '1) begin
                    w_refuse = 1'b1;
                    w_next   = S_DONE;
                end else begin
                    mem_req  = 1'b1;
                    mem_addr = {PAGE, r_sp + SP_W'(1)};
                    if (mem_ack && w_last) w_next = S_DONE;
                end
            end
`ifdef STACK_PEEK_EN
            S_PEEK: begin
                if (WRAP == 0 && w_peek_sp == '1) begin
                    w_refuse = 1'b1;
                    w_next   = S_DONE;
                end else begin
                    mem_req  = 1'b1;
                    mem_addr = {PAGE, w_peek_sp + SP_W'(1)};
                    if (mem_ack && w_last) w_next = S_DONE;
                end
            end
`endif
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // Datapath: command latch, sp movement, byte counter, read capture, error flags
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sp    <= SP_RESET;
            r_len   <= '0;
            r_idx   <= '0;
            r_wdata <= '0;
            r_rdata <= '0;
            r_ovf   <= 1'b0;
            r_udf   <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (cmd_valid) begin
                        r_len   <= w_len;
                        r_idx   <= '0;
                        r_wdata <= cmd_wdata;
                        r_ovf   <= 1'b0;
                        r_udf   <= 1'b0;
                        if (cmd_op == OP_LOAD) r_sp <= cmd_sp_data;
                        if (cmd_op == OP_POP || cmd_op == OP_PEEK) r_rdata <= '0;
                    end
                end
                S_PUSH: begin
                    if (w_refuse) r_ovf <= 1'b1;
                    else if (w_fire) begin
                        r_sp  <= r_sp - SP_W'(1);
                        r_idx <= r_idx + LEN_W'(1);
                    end
                end
                S_POP: begin
                    if (w_refuse) r_udf <= 1'b1;
                    else if (w_fire) begin
                        r_rdata[w_rsel] <= mem_rdata;
                        r_sp            <= r_sp + SP_W'(1);
                        r_idx           <= r_idx + LEN_W'(1);
                    end
                end
`ifdef STACK_PEEK_EN
                S_PEEK: begin
                    if (w_refuse) r_udf <= 1'b1;
                    else if (w_fire) begin
                        r_rdata[w_rsel] <= mem_rdata;
                        r_idx           <= r_idx + LEN_W'(1);
                    end
                end
`endif
                default: ;
            endcase
        end
    end

endmodule
